// File: rtl/patch_assembler.sv
// patch_assembler: packs a raster stream of signed pixels into flat 8x8 patch
// vectors for the convolution stage. A pixel is accepted on s_vld && s_ready.
// A tile is emitted on its last pixel, on s_last, or on flush, and is
// zero-padded above the last written slot. Sticky flags record tiles that end
// early (s_last too soon) or run long (64th pixel without s_last).
module patch_assembler #(
    parameter int FMS_PATCH_SIZE   = 8,
    parameter int INFMS_DATA_WIDTH = 8,
    parameter int TILE_CNT_WIDTH   = 16
) (
    input  logic                                                    clk,
    input  logic                                                    rst_n,
    input  logic [INFMS_DATA_WIDTH-1:0]                             s_pix,
    input  logic                                                    s_vld,
    input  logic                                                    s_last,
    output logic                                                    s_ready,
    input  logic                                                    flush,
    output logic [FMS_PATCH_SIZE*FMS_PATCH_SIZE*INFMS_DATA_WIDTH-1:0] in_fm,
    output logic                                                    infms_data_vld,
    output logic [TILE_CNT_WIDTH-1:0]                               tile_cnt,
    output logic                                                    err_short,
    output logic                                                    err_long,
    input  logic                                                    err_clr
);

    localparam int PATCH_PIX = FMS_PATCH_SIZE * FMS_PATCH_SIZE;
    localparam int PIX_W     = INFMS_DATA_WIDTH;
    localparam int VEC_W     = PATCH_PIX * PIX_W;
    localparam int IDX_W     = $clog2(PATCH_PIX);

    localparam logic [IDX_W-1:0]          IDX_LAST = IDX_W'(PATCH_PIX - 1);
    localparam logic [IDX_W-1:0]          IDX_ONE  = IDX_W'(1);
    localparam logic [TILE_CNT_WIDTH-1:0] CNT_ONE  = TILE_CNT_WIDTH'(1);

    logic                      s_ready_r;
    logic [IDX_W-1:0]          pix_idx_r;
    logic [VEC_W-1:0]          fill_r;
    logic [VEC_W-1:0]          in_fm_r;
    logic                      data_vld_r;
    logic [TILE_CNT_WIDTH-1:0] tile_cnt_r;
    logic                      err_short_r;
    logic                      err_long_r;

    logic                      accept_s;
    logic                      last_slot_s;
    logic                      emit_s;
    logic                      set_short_s;
    logic                      set_long_s;
    logic [VEC_W-1:0]          patch_s;

    // Accept / emit / error-set decisions for the current cycle.
    always_comb begin
        accept_s    = s_vld & s_ready_r;
        last_slot_s = (pix_idx_r == IDX_LAST);
        if (accept_s) begin
            // flush together with a pixel behaves like s_last, minus the error
            emit_s = last_slot_s | s_last | flush;
        end else begin
            emit_s = flush & (pix_idx_r != {IDX_W{1'b0}});
        end
        set_short_s = accept_s & s_last & ~last_slot_s;
        set_long_s  = accept_s & last_slot_s & ~s_last;
    end

    // Patch to publish: stored slots below the index, the live pixel at the
    // index when accepting, zero above. Stale buffer contents never leak out.
    always_comb begin
        patch_s = '0;
        for (int k = 0; k < PATCH_PIX; k++) begin
            if (k < int'(pix_idx_r)) begin
                patch_s[k*PIX_W +: PIX_W] = fill_r[k*PIX_W +: PIX_W];
            end else if ((k == int'(pix_idx_r)) && accept_s) begin
                patch_s[k*PIX_W +: PIX_W] = s_pix;
            end else begin
                patch_s[k*PIX_W +: PIX_W] = '0;
            end
        end
    end

    // Ready comes up one clock after reset release and then stays high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_ready_r <= 1'b0;
        end else begin
            s_ready_r <= 1'b1;
        end
    end

    // Fill index and fill buffer; an emit restarts the tile at slot 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_idx_r <= '0;
            fill_r    <= '0;
        end else if (emit_s) begin
            pix_idx_r <= '0;
        end else if (accept_s) begin
            pix_idx_r                       <= pix_idx_r + IDX_ONE;
            fill_r[pix_idx_r*PIX_W +: PIX_W] <= s_pix;
        end else begin
            pix_idx_r <= pix_idx_r;
        end
    end

    // Published patch, one-cycle strobe and wrapping tile counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_fm_r    <= '0;
            data_vld_r <= 1'b0;
            tile_cnt_r <= '0;
        end else begin
            data_vld_r <= emit_s;
            if (emit_s) begin
                in_fm_r    <= patch_s;
                tile_cnt_r <= tile_cnt_r + CNT_ONE;
            end else begin
                in_fm_r    <= in_fm_r;
                tile_cnt_r <= tile_cnt_r;
            end
        end
    end

    // Sticky error flags; a new error wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_short_r <= 1'b0;
            err_long_r  <= 1'b0;
        end else begin
            err_short_r <= (err_short_r & ~err_clr) | set_short_s;
            err_long_r  <= (err_long_r & ~err_clr) | set_long_s;
        end
    end

    assign s_ready        = s_ready_r;
    assign in_fm          = in_fm_r;
    assign infms_data_vld = data_vld_r;
    assign tile_cnt       = tile_cnt_r;
    assign err_short      = err_short_r;
    assign err_long       = err_long_r;

endmodule

// File: tb/tb_patch_assembler.sv
// Bench for patch_assembler: directed scenarios plus randomized traffic,
// every cycle compared against a queue-based tile model.
module tb_patch_assembler;

    logic         clk;
    logic         rst_n;
    logic [7:0]   s_pix;
    logic         s_vld;
    logic         s_last;
    logic         s_ready;
    logic         flush;
    logic [511:0] in_fm;
    logic         infms_data_vld;
    logic [15:0]  tile_cnt;
    logic         err_short;
    logic         err_long;
    logic         err_clr;

    int n_checks;
    int n_bad;

    // model state
    logic [7:0]   cur_q[$];
    logic [511:0] m_fm;
    logic         m_vld;
    logic [15:0]  m_cnt;
    logic         m_short;
    logic         m_long;
    logic         m_ready;

    patch_assembler dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .s_pix          (s_pix),
        .s_vld          (s_vld),
        .s_last         (s_last),
        .s_ready        (s_ready),
        .flush          (flush),
        .in_fm          (in_fm),
        .infms_data_vld (infms_data_vld),
        .tile_cnt       (tile_cnt),
        .err_short      (err_short),
        .err_long       (err_long),
        .err_clr        (err_clr)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    task automatic compare_all();
        check_eq("strobe",    {511'd0, infms_data_vld}, {511'd0, m_vld});
        check_eq("in_fm",     in_fm, m_fm);
        check_eq("tile_cnt",  {496'd0, tile_cnt}, {496'd0, m_cnt});
        check_eq("err_short", {511'd0, err_short}, {511'd0, m_short});
        check_eq("err_long",  {511'd0, err_long}, {511'd0, m_long});
        check_eq("s_ready",   {511'd0, s_ready}, {511'd0, m_ready});
    endtask

    task automatic model_reset();
        cur_q.delete();
        m_fm    = '0;
        m_vld   = 1'b0;
        m_cnt   = 16'd0;
        m_short = 1'b0;
        m_long  = 1'b0;
        m_ready = 1'b0;
    endtask

    // One clock: drive inputs (called just after a negedge), advance model, compare.
    task automatic step(input logic vld, input logic [7:0] pix, input logic last,
                        input logic fl, input logic clr);
        logic acc;
        logic emit;
        logic n_short;
        logic n_long;
        s_vld   = vld;
        s_pix   = pix;
        s_last  = last;
        flush   = fl;
        err_clr = clr;
        acc     = vld && m_ready;
        emit    = 1'b0;
        n_short = 1'b0;
        n_long  = 1'b0;
        if (acc) begin
            if (last && cur_q.size() < 63) n_short = 1'b1;
            if (!last && cur_q.size() == 63) n_long = 1'b1;
            cur_q.push_back(pix);
            if (cur_q.size() == 64 || last || fl) emit = 1'b1;
        end else if (fl && cur_q.size() > 0) begin
            emit = 1'b1;
        end
        @(posedge clk);
        m_vld = emit;
        if (emit) begin
            m_fm = '0;
            foreach (cur_q[i]) m_fm[i*8 +: 8] = cur_q[i];
            m_cnt = m_cnt + 16'd1;
            cur_q.delete();
        end
        m_short = (m_short && !clr) || n_short;
        m_long  = (m_long && !clr) || n_long;
        m_ready = 1'b1;
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic full_reset();
        rst_n = 1'b0;
        s_vld = 1'b0; s_pix = 8'd0; s_last = 1'b0; flush = 1'b0; err_clr = 1'b0;
        model_reset();
        #1;
        compare_all();
        @(negedge clk);
        compare_all();
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_bad    = 0;
        full_reset();
        idle(1);

        // full tile, value = index
        for (int i = 0; i < 64; i++) step(1'b1, 8'(i), (i == 63), 1'b0, 1'b0);
        idle(2);

        // back-to-back tiles of +1 then -1
        for (int i = 0; i < 128; i++)
            step(1'b1, (i < 64) ? 8'h01 : 8'hFF, (i % 64) == 63, 1'b0, 1'b0);
        idle(1);

        // short tile, then clear of the sticky flag
        for (int i = 0; i < 10; i++) step(1'b1, 8'd5, (i == 9), 1'b0, 1'b0);
        idle(3);
        step(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        idle(1);

        // long tile, then 3 pixels and a standalone flush
        for (int i = 0; i < 64; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 8'h80, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);   // flush on empty tile: nothing
        // new error and clear on the same cycle: error stays
        for (int i = 0; i < 63; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h7F, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        // flush together with a pixel
        for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom), 1'b0, (i == 3), 1'b0);
        idle(1);

        // reset mid-tile
        for (int i = 0; i < 30; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        full_reset();
        step(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);   // not accepted: ready still low
        begin
            int sent;
            sent = 0;
            while (sent < 64) begin
                if ($urandom_range(0, 2) == 0) begin
                    idle(1);
                end else begin
                    step(1'b1, 8'($urandom), (sent == 63), 1'b0, 1'b0);
                    sent++;
                end
            end
        end
        idle(2);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic v;
            logic l;
            logic f;
            v = ($urandom_range(0, 3) != 0);
            l = ($urandom_range(0, 39) == 0);
            f = l ? 1'b0 : ($urandom_range(0, 49) == 0);
            step(v, 8'($urandom), l, f, ($urandom_range(0, 19) == 0));
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
